// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the IF stage and imem
interface fetch_unit_if #(
   parameter int WORD_SIZE = 16
);
   logic                 i_readM;
   logic [WORD_SIZE-1:0] i_address;
   logic [WORD_SIZE-1:0] i_data;
   logic                 i_ready;
   modport master(output i_readM, i_address, input i_data, i_ready);
   modport slave(input i_readM, i_address, output i_data, i_ready);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC register, direct-mapped BTB and imem handshake; BTB_2BIT_COUNTER_EN adds 2-bit counters
module fetch_unit #(
   parameter int                   WORD_SIZE    = 16,
   parameter int                   BTB_IDX_BITS = 3,
   parameter logic [WORD_SIZE-1:0] RESET_PC     = 16'h0000,
   parameter logic [WORD_SIZE-1:0] NOP_INST     = 16'hF01C
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   fetch_unit_if.master         imem,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirectPC,
   input  logic                 btbUpdate,
   input  logic [WORD_SIZE-1:0] btbUpdatePC,
   input  logic [WORD_SIZE-1:0] btbUpdateTarget,
   input  logic                 btbUpdateTaken,
   output logic                 latchWrite,
   output logic [WORD_SIZE-1:0] outPC,
   output logic [WORD_SIZE-1:0] outInst,
   output logic [WORD_SIZE-1:0] outPred,
   output logic [WORD_SIZE-1:0] outTarget
);
   localparam int ENTRIES = 1 << BTB_IDX_BITS;
   localparam int TAG_W   = WORD_SIZE - BTB_IDX_BITS;

   typedef enum logic {FETCH, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q [ENTRIES];
   logic [TAG_W-1:0]     tag_d [ENTRIES];
   logic [WORD_SIZE-1:0] target_q [ENTRIES];
   logic [WORD_SIZE-1:0] target_d [ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
   logic [1:0]           cnt_q [ENTRIES];
   logic [1:0]           cnt_d [ENTRIES];
`endif

   logic [BTB_IDX_BITS-1:0] idx, upd_idx;
   logic                    hit, taken, upd_hit;
   logic [WORD_SIZE-1:0]    pc_inc, pred;

   assign idx     = pc_q[BTB_IDX_BITS-1:0];
   assign hit     = valid_q[idx] && tag_q[idx] == pc_q[WORD_SIZE-1:BTB_IDX_BITS];
`ifdef BTB_2BIT_COUNTER_EN
   assign taken   = hit && cnt_q[idx][1];
`else
   assign taken   = hit;
`endif
   assign pc_inc  = pc_q + WORD_SIZE'(1);
   assign pred    = taken ? target_q[idx] : pc_inc;
   assign upd_idx = btbUpdatePC[BTB_IDX_BITS-1:0];
   assign upd_hit = valid_q[upd_idx] && tag_q[upd_idx] == btbUpdatePC[WORD_SIZE-1:BTB_IDX_BITS];

   // Next-state, next-PC and IF/ID outputs; redirect beats stall beats accept, all gated by reset
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      latchWrite     = 1'b0;
      outInst        = NOP_INST;
      outPC          = '0;
      outPred        = '0;
      outTarget      = '0;
      imem.i_readM   = Reset_N && state_q == FETCH;
      imem.i_address = pc_q;
      if (Reset_N) begin
         if (redirect) begin
            pc_d       = redirectPC;
            state_d    = FLUSH;
            latchWrite = 1'b1;
         end else if (state_q == FLUSH) begin
            state_d = FETCH;
         end else if (imem.i_ready && !stall) begin
            pc_d       = pred;
            latchWrite = 1'b1;
            outInst    = imem.i_data;
            outPC      = pc_inc;
            outPred    = pred;
            outTarget  = hit ? target_q[idx] : '0;
         end
      end
   end

   // BTB training from EX-resolved branches
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
`ifdef BTB_2BIT_COUNTER_EN
      cnt_d    = cnt_q;
      if (btbUpdate && upd_hit) begin
         cnt_d[upd_idx] = btbUpdateTaken ? (cnt_q[upd_idx] == 2'b11 ? 2'b11 : cnt_q[upd_idx] + 2'b01)
                                         : (cnt_q[upd_idx] == 2'b00 ? 2'b00 : cnt_q[upd_idx] - 2'b01);
         if (btbUpdateTaken) target_d[upd_idx] = btbUpdateTarget;
      end else if (btbUpdate && btbUpdateTaken) begin
         valid_d[upd_idx]  = 1'b1;
         tag_d[upd_idx]    = btbUpdatePC[WORD_SIZE-1:BTB_IDX_BITS];
         target_d[upd_idx] = btbUpdateTarget;
         cnt_d[upd_idx]    = 2'b10;
      end
`else
      if (btbUpdate && btbUpdateTaken) begin
         valid_d[upd_idx]  = 1'b1;
         tag_d[upd_idx]    = btbUpdatePC[WORD_SIZE-1:BTB_IDX_BITS];
         target_d[upd_idx] = btbUpdateTarget;
      end else if (btbUpdate && upd_hit) begin
         valid_d[upd_idx] = 1'b0;
      end
`endif
   end

   // State, PC and BTB registers
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
`ifdef BTB_2BIT_COUNTER_EN
            cnt_q[i]    <= 2'b01;
`endif
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
`ifdef BTB_2BIT_COUNTER_EN
         cnt_q    <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
   localparam logic [15:0] NOP = 16'hF01C;

   logic        Clk = 1'b0;
   logic        Reset_N;
   logic        stall, redirect, btbUpdate, btbUpdateTaken;
   logic [15:0] redirectPC, btbUpdatePC, btbUpdateTarget;
   logic        latchWrite;
   logic [15:0] outPC, outInst, outPred, outTarget;
   int          checks = 0;
   int          errors = 0;

   fetch_unit_if #(.WORD_SIZE(16)) bus ();

   fetch_unit dut (
      .Clk(Clk), .Reset_N(Reset_N), .imem(bus.master),
      .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
      .btbUpdate(btbUpdate), .btbUpdatePC(btbUpdatePC), .btbUpdateTarget(btbUpdateTarget),
      .btbUpdateTaken(btbUpdateTaken), .latchWrite(latchWrite), .outPC(outPC),
      .outInst(outInst), .outPred(outPred), .outTarget(outTarget)
   );

   always #5 Clk = ~Clk;

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_redirect(input logic [15:0] pc);
      redirect = 1'b1;
      redirectPC = pc;
      cyc();
      redirect = 1'b0;
      cyc();
   endtask

   task automatic btb_update(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
      stall = 1'b1;
      btbUpdate = 1'b1;
      btbUpdatePC = pc;
      btbUpdateTarget = tgt;
      btbUpdateTaken = tk;
      cyc();
      btbUpdate = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_reset();
      Reset_N = 1'b0;
      stall = 0; redirect = 0; redirectPC = 0; btbUpdate = 0; btbUpdatePC = 0;
      btbUpdateTarget = 0; btbUpdateTaken = 0; bus.i_ready = 0; bus.i_data = 0;
      #2;
      checks++; if (latchWrite !== 1'b0) begin errors++; $display("FAIL rst_lw got %b exp 0", latchWrite); end
      checks++; if (bus.i_readM !== 1'b0) begin errors++; $display("FAIL rst_readM got %b exp 0", bus.i_readM); end
      checks++; if (outInst !== NOP) begin errors++; $display("FAIL rst_inst got %h exp %h", outInst, NOP); end
      checks++; if ({outPC, outPred, outTarget} !== 48'h0) begin errors++; $display("FAIL rst_outs got %h %h %h exp 0", outPC, outPred, outTarget); end
      cyc();
      cyc();
      Reset_N = 1'b1;
   endtask

   task automatic test_sequential();
      bus.i_ready = 1'b1;
      bus.i_data = 16'h1234;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.i_address !== 16'(k)) begin errors++; $display("FAIL seq_addr got %h exp %h", bus.i_address, 16'(k)); end
         checks++; if (latchWrite !== 1'b1 || outInst !== 16'h1234) begin errors++; $display("FAIL seq_lw got %b/%h exp 1/1234", latchWrite, outInst); end
         checks++; if (outPC !== 16'(k + 1) || outPred !== 16'(k + 1)) begin errors++; $display("FAIL seq_pc got %h/%h exp %h", outPC, outPred, 16'(k + 1)); end
         cyc();
      end
   endtask

   task automatic test_wait();
      cyc();
      cyc();
      bus.i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.i_readM !== 1'b1 || bus.i_address !== 16'd5) begin errors++; $display("FAIL wait_req got %b/%h exp 1/0005", bus.i_readM, bus.i_address); end
         checks++; if (latchWrite !== 1'b0) begin errors++; $display("FAIL wait_lw got %b exp 0", latchWrite); end
         cyc();
      end
   endtask

   task automatic test_stall();
      bus.i_ready = 1'b1;
      cyc();
      cyc();
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (latchWrite !== 1'b0 || bus.i_address !== 16'd7 || bus.i_readM !== 1'b1) begin errors++; $display("FAIL stall_hold got %b/%h/%b exp 0/0007/1", latchWrite, bus.i_address, bus.i_readM); end
         cyc();
      end
      stall = 1'b0;
      #1;
      checks++; if (latchWrite !== 1'b1 || outPC !== 16'd8) begin errors++; $display("FAIL stall_rel got %b/%h exp 1/0008", latchWrite, outPC); end
      cyc();
      checks++; if (bus.i_address !== 16'd8) begin errors++; $display("FAIL stall_next got %h exp 0008", bus.i_address); end
   endtask

   task automatic test_btb();
      btb_update(16'd4, 16'd20, 1'b1);
      do_redirect(16'd4);
      #1;
      checks++; if (bus.i_address !== 16'd4) begin errors++; $display("FAIL btb_addr got %h exp 0004", bus.i_address); end
      checks++; if (outPred !== 16'd20 || outTarget !== 16'd20 || outPC !== 16'd5) begin errors++; $display("FAIL btb_hit got %h/%h/%h exp 0014/0014/0005", outPred, outTarget, outPC); end
      cyc();
      checks++; if (bus.i_address !== 16'd20) begin errors++; $display("FAIL btb_jump got %h exp 0014", bus.i_address); end
      btb_update(16'd4, 16'd20, 1'b0);
      do_redirect(16'd4);
      #1;
      checks++; if (outPred !== 16'd5) begin errors++; $display("FAIL btb_nt_pred got %h exp 0005", outPred); end
`ifdef BTB_2BIT_COUNTER_EN
      checks++; if (outTarget !== 16'd20) begin errors++; $display("FAIL btb_nt_tgt got %h exp 0014", outTarget); end
`else
      checks++; if (outTarget !== 16'd0) begin errors++; $display("FAIL btb_nt_tgt got %h exp 0000", outTarget); end
`endif
      cyc();
   endtask

   task automatic test_redirect();
      stall = 1'b1;
      bus.i_ready = 1'b1;
      redirect = 1'b1;
      redirectPC = 16'd40;
      #1;
      checks++; if (latchWrite !== 1'b1 || outInst !== NOP) begin errors++; $display("FAIL redir_flush got %b/%h exp 1/%h", latchWrite, outInst, NOP); end
      checks++; if ({outPC, outPred, outTarget} !== 48'h0) begin errors++; $display("FAIL redir_zero got %h %h %h exp 0", outPC, outPred, outTarget); end
      cyc();
      redirect = 1'b0;
      stall = 1'b0;
      #1;
      checks++; if (bus.i_readM !== 1'b0 || latchWrite !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b/%b exp 0/0", bus.i_readM, latchWrite); end
      cyc();
      checks++; if (bus.i_readM !== 1'b1 || bus.i_address !== 16'd40) begin errors++; $display("FAIL redir_fetch got %b/%h exp 1/0028", bus.i_readM, bus.i_address); end
      checks++; if (latchWrite !== 1'b1 || outPC !== 16'd41) begin errors++; $display("FAIL redir_acc got %b/%h exp 1/0029", latchWrite, outPC); end
      cyc();
   endtask

   task automatic test_async_reset();
      btb_update(16'd4, 16'd20, 1'b1);
      do_redirect(16'd4);
      #1;
      checks++; if (outPred !== 16'd20) begin errors++; $display("FAIL ar_prehit got %h exp 0014", outPred); end
      cyc();
      bus.i_ready = 1'b0;
      do_redirect(16'd9);
      checks++; if (bus.i_address !== 16'd9 || bus.i_readM !== 1'b1) begin errors++; $display("FAIL ar_wait got %h/%b exp 0009/1", bus.i_address, bus.i_readM); end
      Reset_N = 1'b0;
      #1;
      checks++; if (bus.i_readM !== 1'b0 || latchWrite !== 1'b0 || outInst !== NOP) begin errors++; $display("FAIL ar_outs got %b/%b/%h exp 0/0/%h", bus.i_readM, latchWrite, outInst, NOP); end
      checks++; if (bus.i_address !== 16'd0) begin errors++; $display("FAIL ar_pc got %h exp 0000", bus.i_address); end
      cyc();
      Reset_N = 1'b1;
      bus.i_ready = 1'b1;
      do_redirect(16'd4);
      #1;
      checks++; if (outPred !== 16'd5 || outTarget !== 16'd0) begin errors++; $display("FAIL ar_btbclr got %h/%h exp 0005/0000", outPred, outTarget); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait();
      test_stall();
      test_btb();
      test_redirect();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage that sits directly upstream of the IF/ID pipeline latch and drives all of its inputs: PC+1, instruction, predicted next PC, BTB target and latch write enable.
- Owns the PC register, a direct-mapped branch target buffer (BTB) and the instruction-memory request handshake.
- Accepts stall requests from the hazard unit and branch-resolution redirects and BTB updates from EX.

Parameters:
- WORD_SIZE, 16, datapath and PC width.
- BTB_IDX_BITS, 3, BTB index width; the BTB has 2^BTB_IDX_BITS entries, indexed by PC[BTB_IDX_BITS-1:0].
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INST, 16'hF01C, instruction word emitted on flush.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_N  in  1  asynchronous, active-low reset.
- i_readM  out  1  instruction-memory read request.
- i_address  out  WORD_SIZE  fetch address; equals PC while i_readM=1.
- i_data  in  WORD_SIZE  instruction word; valid when i_ready=1.
- i_ready  in  1  memory response valid, same cycle as i_data.
- stall  in  1  hazard unit requests IF/ID hold.
- redirect  in  1  EX detected a mispredict.
- redirectPC  in  WORD_SIZE  correct next PC.
- btbUpdate  in  1  EX resolved a branch this cycle.
- btbUpdatePC  in  WORD_SIZE  PC of the resolved branch.
- btbUpdateTarget  in  WORD_SIZE  resolved target.
- btbUpdateTaken  in  1  resolved outcome.
- latchWrite  out  1  IF/ID write enable.
- outPC  out  WORD_SIZE  PC+1 of the fetched instruction.
- outInst  out  WORD_SIZE  fetched instruction.
- outPred  out  WORD_SIZE  predicted next PC.
- outTarget  out  WORD_SIZE  BTB target (0 on miss).

Behaviour:
- Reset (async, Reset_N=0):
  - PC=RESET_PC, state=FETCH.
  - All BTB valid bits=0, counters=2'b01.
  - Outputs: latchWrite=0, i_readM=0, outInst=NOP_INST, outPC/outPred/outTarget=0.
  - Reset mid-request abandons the request; no response is consumed.
- States:
  - FETCH: i_readM=1, i_address=PC. Holds until i_ready=1.
  - FLUSH: one cycle. i_readM=0. Next state is FETCH.
- Lookup (combinational on PC):
  - hit = valid[idx] && tag[idx]==PC[WORD_SIZE-1:BTB_IDX_BITS].
  - taken = hit && counter[idx][1].
  - pred = taken ? target[idx] : PC+1. Addition wraps modulo 2^WORD_SIZE.
- Accept in FETCH when i_ready=1, stall=0 and redirect=0:
  - latchWrite=1 combinationally.
  - outInst=i_data, outPC=PC+1, outPred=pred, outTarget=hit?target:0.
  - PC<=pred at the next edge.
- Hold:
  - In FETCH with stall=1, or with i_ready=0: latchWrite=0 and PC holds.
  - i_readM stays 1 and i_address stays PC.
  - A response arriving during a stall is discarded; the same PC is refetched.
- Redirect priority: redirect > stall > accept.
  - redirect=1 in any state: PC<=redirectPC, next state=FLUSH.
  - latchWrite=1 with outInst=NOP_INST, outPC=0, outPred=0, outTarget=0; this flushes IF/ID even if stall=1.
  - Any concurrent i_ready response is dropped.
- BTB update (edge, btbUpdate=1, idx from btbUpdatePC):
  - Tag hit: counter saturating +1 if taken, -1 if not taken (bounds 0..3). Target<=btbUpdateTarget when taken.
  - Miss and taken: allocate/replace with valid=1, new tag and target, counter=2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update on the same index: lookup sees the pre-update entry.
- The PC register and every BTB field are registered; outputs to IF/ID are combinational, so IF/ID captures at the same edge.

Optional Feature:
- Macro: BTB_2BIT_COUNTER_EN.
- Defined: 2-bit saturating counters as described above.
- Undefined:
  - Counters are removed and taken = hit.
  - An update with not-taken on a tag hit clears valid.
  - A taken update allocates or refreshes the entry.

Test Plan:
- Reset, then i_ready=1 every cycle with i_data=16'h1234: PC sequence 0,1,2; outPC=1,2,3; latchWrite=1 each cycle; outPred=PC+1.
- i_ready held 0 for 3 cycles at PC=5: i_readM=1 and i_address=5 throughout; latchWrite=0; PC stays 5.
- stall=1 for 2 cycles with i_ready=1 at PC=7: latchWrite=0 and PC=7; after release, inst at 7 is accepted and PC=8.
- btbUpdate with PC=4, target=20, taken=1, then fetch PC=4: outPred=20, outTarget=20, next PC=20. A not-taken update (counter 2→1) makes the next fetch of PC=4 predict 5.
- redirect=1 with redirectPC=40 while stall=1 and i_ready=1: outInst=NOP_INST with latchWrite=1, then 1 cycle with i_readM=0, then fetch at 40.
- Reset_N pulsed low mid-wait at PC=9: outputs go to reset values immediately; PC=RESET_PC; BTB hit on PC=4 no longer occurs.
